vga_timing_rx: RTL
==================

// Module: vga_timing_rx
// PURPOSE
// - Receive end of the 1280x800 VGA raster link: samples hsync/vsync/RGB as driven by the display timing generator.
// - Recovers pixel coordinates and data-enable; declares timing lock only after complete frames measure correctly.
// - Used for loopback self-check of the video output path and as front end of the frame-capture path.
// PARAMETERS
// - H_TOTAL        1680  clocks per line
// - H_ACT_START    336   line clock index of first visible pixel (sync 136 + back porch 200)
// - H_ACTIVE       1280  visible pixels per line
// - V_TOTAL        828   lines per frame
// - V_ACT_START    27    line index of first visible line
// - V_ACTIVE       800   visible lines per frame
// - HSYNC_POL      0     asserted level of hsync_in (0 = active low)
// - VSYNC_POL      1     asserted level of vsync_in (1 = active high)
// - LOCK_FRAMES    2     consecutive good frames required for lock
// PORTS
// - clk          in   1   pixel clock; same domain as the timing generator
// - rst          in   1   synchronous reset, active high
// - hsync_in     in   1   horizontal sync
// - vsync_in     in   1   vertical sync
// - red_in, green_in, blue_in  in  4 each  pixel data
// - de           out  1   visible pixel valid
// - x            out  11  pixel column, 0..1279
// - y            out  10  pixel row, 0..799
// - pix_rgb      out  12  {red,green,blue} of the pixel at (x,y)
// - frame_start  out  1   1-cycle pulse at recovered line 0, clock 0
// - locked       out  1   timing lock status
// - err_count    out  8   saturating count of timing errors since reset
// BEHAVIOUR
// - Reset: all outputs 0; state SEARCH; internal counters 0.
// - Inputs are registered once (stage 1); all outputs are registered (stage 2).
//   Fixed latency: de/x/y/pix_rgb describe the input sample taken 2 clk edges earlier.
// - Sync edges: h_edge = hsync goes to HSYNC_POL (inactive -> active) between consecutive stage-1 samples.
//   v_edge = h_edge AND vsync at HSYNC_POL-active sample == VSYNC_POL AND vsync was inactive at the previous h_edge.
// - hc (11b): hc = 0 on h_edge, else hc+1, saturating at H_TOTAL. hc then equals the transmitter clock index of the sample.
// - vc (10b): vc = 0 on v_edge, vc+1 on any other h_edge, saturating at V_TOTAL.
// - Line error: only in VERIFY or LOCKED. Raised on h_edge with hc != H_TOTAL-1, or when hc reaches H_TOTAL (hsync lost).
// - Frame error: only in VERIFY or LOCKED. Raised on v_edge with vc != V_TOTAL-1, or when vc reaches V_TOTAL (vsync lost).
// - Line and frame errors occurring in the same cycle count once.
// - err_count += 1 per error event; it holds at 255.
// - FSM:
//   - SEARCH -> VERIFY on the first v_edge; good = 0.
//   - VERIFY: an error -> SEARCH. Each error-free v_edge increments good. good == LOCK_FRAMES -> LOCKED.
//   - LOCKED: an error -> SEARCH; locked drops to 0 in the same output cycle the error is registered.
// - locked = (state == LOCKED), registered.
// - Visible test: H_ACT_START <= hc < H_ACT_START+H_ACTIVE AND V_ACT_START <= vc < V_ACT_START+V_ACTIVE.
// - de = locked AND visible. When de=1: x = hc-H_ACT_START, y = vc-V_ACT_START, pix_rgb = sampled RGB.
// - When de=0: x, y and pix_rgb are all 0.
// - frame_start = locked AND stage-1 sample has hc==0 AND vc==0. It fires on the v_edge itself.
// - Reset mid-frame: everything returns to the reset state on the next edge. Lock restarts from SEARCH.
// TESTING
// - Reset: rst=1 for 3 clk during a locked stream -> next cycle locked=0, de=0, x=y=0, err_count=0.
// - Nominal stream, H_TOTAL/V_TOTAL as parameterised: locked=1 two cycles after the 3rd vsync assertion.
//   - Next frame: first de at (x=0,y=0), 2 clk after pin sample at tx hcount=336, vcount=27.
//   - Last de at (1279,799). Exactly 1,024,000 de cycles per frame.
// - Data path: RGB = {x[3:0], y[3:0], 4'hA} -> pix_rgb matches, 2-clk latency, 0 outside the visible region.
// - Short line: one line of 1679 clk while locked -> err_count=1, locked=0, de=0.
//   Relock at the 3rd following v_edge (SEARCH + 2 good frames).
// - Lost sync: hsync held inactive -> err_count+1 when hc hits 1680, locked=0.
//   Also: vsync removed -> frame error when vc hits 828.
// - Polarity: HSYNC_POL=1, VSYNC_POL=0 with both syncs inverted -> identical lock time and de/x/y trace as nominal.

Source files
------------

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive end of the VGA raster link.
// Recovers pixel coordinates, data-enable and timing lock from hsync/vsync.
module vga_timing_rx #(
    parameter int H_TOTAL     = 1680,
    parameter int H_ACT_START = 336,
    parameter int H_ACTIVE    = 1280,
    parameter int V_TOTAL     = 828,
    parameter int V_ACT_START = 27,
    parameter int V_ACTIVE    = 800,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_count
);
    localparam logic [10:0] HT  = 11'(H_TOTAL);
    localparam logic [10:0] HAS = 11'(H_ACT_START);
    localparam logic [10:0] HAE = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0]  VT  = 10'(V_TOTAL);
    localparam logic [9:0]  VAS = 10'(V_ACT_START);
    localparam logic [9:0]  VAE = 10'(V_ACT_START + V_ACTIVE);
    localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t      state;
    logic        hs_r;
    logic        vs_r;
    logic        hs_p;
    logic        v_seen;
    logic [11:0] rgb_r;
    logic [10:0] hc_q;
    logic [10:0] hc_d;
    logic [9:0]  vc_q;
    logic [9:0]  vc_d;
    logic [3:0]  good;
    logic        h_act;
    logic        v_act;
    logic        h_edge;
    logic        v_edge;
    logic        line_err;
    logic        frame_err;
    logic        err;
    logic        lock_d;
    logic        vis;

    assign h_act  = (hs_r == HSYNC_POL);
    assign v_act  = (vs_r == VSYNC_POL);
    assign h_edge = h_act & ~hs_p;
    assign v_edge = h_edge & v_act & ~v_seen;

    always_comb begin
        hc_d = (hc_q == HT) ? HT : hc_q + 11'd1;
        if (h_edge)
            hc_d = '0;
        vc_d = vc_q;
        if (v_edge)
            vc_d = '0;
        else if (h_edge && vc_q != VT)
            vc_d = vc_q + 10'd1;
    end

    // The "lost" terms fire once, on the step into saturation.
    assign line_err  = (h_edge && hc_q != HT - 11'd1) ||
                       (!h_edge && hc_q == HT - 11'd1);
    assign frame_err = (v_edge && vc_q != VT - 10'd1) ||
                       (h_edge && !v_edge && vc_q == VT - 10'd1);
    assign err       = (state != SEARCH) && (line_err || frame_err);

    assign lock_d = !err && ((state == LOCKED) ||
                    (state == VERIFY && v_edge && good == LF - 4'd1));

    assign vis = (hc_d >= HAS) && (hc_d < HAE) &&
                 (vc_d >= VAS) && (vc_d < VAE);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_r        <= ~HSYNC_POL;
            vs_r        <= ~VSYNC_POL;
            rgb_r       <= '0;
            hs_p        <= 1'b0;
            v_seen      <= 1'b0;
            hc_q        <= '0;
            vc_q        <= '0;
            state       <= SEARCH;
            good        <= '0;
            err_count   <= '0;
            locked      <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            hs_r  <= hsync_in;
            vs_r  <= vsync_in;
            rgb_r <= {red_in, green_in, blue_in};
            hs_p  <= h_act;
            if (h_edge)
                v_seen <= v_act;
            hc_q <= hc_d;
            vc_q <= vc_d;

            if (err) begin
                state <= SEARCH;
            end else begin
                unique case (state)
                    SEARCH: begin
                        if (v_edge) begin
                            state <= VERIFY;
                            good  <= '0;
                        end
                    end
                    VERIFY: begin
                        if (v_edge) begin
                            good <= good + 4'd1;
                            if (good == LF - 4'd1)
                                state <= LOCKED;
                        end
                    end
                    default: ;
                endcase
            end

            if (err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            locked      <= lock_d;
            de          <= lock_d && vis;
            x           <= (lock_d && vis) ? hc_d - HAS : '0;
            y           <= (lock_d && vis) ? vc_d - VAS : '0;
            pix_rgb     <= (lock_d && vis) ? rgb_r : '0;
            frame_start <= lock_d && hc_d == '0 && vc_d == '0;
        end
    end
endmodule
